// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: alignment check, load extract/extend, store lane merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] mem_word,
  input  logic [31:0] st_data,
  output logic        align_err,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  // Sign- or zero-extend a right-justified byte/half to 32 bits.
  function automatic logic [31:0] extend(input logic [15:0] v, input logic is_half,
                                         input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = v[7:0];
    h = v;
    if (!sgn)        r = is_half ? {16'h0000, v} : {24'h000000, v[7:0]};
    else if (is_half) r = 32'(h);
    else             r = 32'(b);
    return r;
  endfunction

  logic [4:0]  lane_sh;
  logic [31:0] shifted;

  assign lane_sh = {addr_lo, 3'b000};
  assign shifted = mem_word >> lane_sh;

  // Decode alignment, extract the addressed lanes and merge store data into the word.
  always_comb begin
    align_err = 1'b0;
    ld_data   = 32'h0;
    st_word   = mem_word;
    case (size)
      SZ_BYTE: begin
        ld_data = extend({8'h00, shifted[7:0]}, 1'b0, is_signed);
        st_word = (mem_word & ~(32'h0000_00FF << lane_sh)) |
                  ((st_data & 32'h0000_00FF) << lane_sh);
      end
      SZ_HALF: begin
        align_err = addr_lo[0];
        ld_data   = extend(shifted[15:0], 1'b1, is_signed);
        st_word   = (mem_word & ~(32'h0000_FFFF << lane_sh)) |
                    ((st_data & 32'h0000_FFFF) << lane_sh);
      end
      SZ_WORD: begin
        align_err = (addr_lo != 2'b00);
        ld_data   = mem_word;
        st_word   = st_data;
      end
      default: begin
        align_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores against a word-wide data memory,
// with read-modify-write for sub-word stores and one response per request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int WORD_ADDR  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    return (WORD_ADDR != 0) ? {2'b00, a[31:2]} : {a[31:2], 2'b00};
  endfunction

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        capture;
  logic [1:0]  sel_size;
  logic [1:0]  sel_addr_lo;
  logic        align_err;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_we     = (state_q == ST_WRITE);
  assign accept     = req_valid && (state_q == ST_IDLE);
  // Read data is valid in ACCESS for an async memory, in WAIT for a registered one.
  assign capture    = ((state_q == ST_ACCESS) && (MEM_RD_LAT == 0)) || (state_q == ST_WAIT);

  // In IDLE the lane logic checks the incoming request; afterwards it works on latched fields.
  assign sel_size    = (state_q == ST_IDLE) ? req_size      : size_q;
  assign sel_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

  lsu_lane_align u_align (
    .size      (sel_size),
    .addr_lo   (sel_addr_lo),
    .is_signed (signed_q),
    .mem_word  (mem_rdata),
    .st_data   (wdata_q),
    .align_err (align_err),
    .ld_data   (ld_data),
    .st_word   (st_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (align_err)                         state_d = ST_RESP;
          else if (req_we && req_size == SZ_WORD) state_d = ST_WRITE;
          else                                   state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (MEM_RD_LAT == 0) state_d = we_q ? ST_WRITE : ST_RESP;
        else                 state_d = ST_WAIT;
      end
      ST_WAIT:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Latch all request fields on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      addr_lo_q <= 2'b00;
      wdata_q   <= 32'h0;
      rd_q      <= 5'd0;
    end else if (accept) begin
      we_q      <= req_we;
      size_q    <= req_size;
      signed_q  <= req_signed;
      addr_lo_q <= req_addr[1:0];
      wdata_q   <= req_wdata;
      rd_q      <= req_rd;
    end
  end

  // Memory address/data: loaded for legal accesses, merged word loaded on capture, else held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      if (accept && !align_err) begin
        mem_addr <= map_addr(req_addr);
        if (req_we && req_size == SZ_WORD) mem_wdata <= req_wdata;
      end
      if (capture && we_q) mem_wdata <= st_word;
    end
  end

  // Response fields: set on entry to RESP and held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'h0;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept && align_err) begin
        resp_rdata <= 32'h0;
        resp_rd    <= req_rd;
        resp_err   <= 1'b1;
      end
      if (capture && !we_q) begin
        resp_rdata <= ld_data;
        resp_rd    <= rd_q;
        resp_err   <= 1'b0;
      end
      if (state_q == ST_WRITE) begin
        resp_rdata <= 32'h0;
        resp_rd    <= rd_q;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule
